neighbors_above_buf: RTL and testbench

NEIGHBORS_ABOVE_BUF -- requirements
Module: neighbors_above_buf

---
 rtl/neighbors_above_buf_if.sv | 41 ++++
 rtl/neighbors_above_buf.sv | 150 +++++++++++++++
 tb/tb_neighbors_above_buf.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/neighbors_above_buf_if.sv
// ----------------------------------------------------------------------------
// neighbors_above_buf_if
//   Read/write bus of the above-neighbour line buffer.
//
//   Handshake: wr_en pushes wr_data in the same cycle and has no back-pressure.
//   A write into a full buffer is dropped. rd_en is a request qualified by fbls
//   and also has no back-pressure. rd_valid is asserted exactly one cycle after
//   every accepted rd_en. rd_data holds its last value while rd_valid is low.
//
//   Signals:
//     fbls     : first block line of slice (reads return the default row)
//     wr_en    : push one block bottom row
//     wr_data  : ENTRY_W-bit row to push
//     rd_en    : above-neighbour read request
//     rd_valid : rd_data valid (one cycle after rd_en)
//     rd_data  : popped entry or default row
//
//   Modports: master = neighbour consumer/producer, slave = the buffer.
// ----------------------------------------------------------------------------
interface neighbors_above_buf_if #(
    parameter int BITS = 14
);
    localparam int ENTRY_W = 24 * BITS;

    logic               fbls;
    logic               wr_en;
    logic [ENTRY_W-1:0] wr_data;
    logic               rd_en;
    logic               rd_valid;
    logic [ENTRY_W-1:0] rd_data;

    modport master (
        output fbls, wr_en, wr_data, rd_en,
        input  rd_valid, rd_data
    );

    modport slave (
        input  fbls, wr_en, wr_data, rd_en,
        output rd_valid, rd_data
    );
endinterface

// File: rtl/neighbors_above_buf.sv
// ----------------------------------------------------------------------------
// neighbors_above_buf
//   Circular buffer holding the bottom row of each reconstructed 8x2 block of
//   the previous block line. The next block line reads these rows back as
//   above neighbours. There is one entry per 8-pixel block. The depth is
//   MAX_SLICE_WIDTH/8.
//
//   Ports:
//     clk           : clock, all state on the rising edge
//     rst_n         : asynchronous active-low reset
//     flush         : sync clear of pointers, count, error flags and rd_valid
//     sos           : start of slice, sync clear of pointers and count
//     bus           : slave modport of neighbors_above_buf_if (wr/rd/fbls)
//     count         : current occupancy
//     full / empty  : count == DEPTH / count == 0
//     overflow_err  : sticky, write attempted while full
//     underflow_err : sticky, read attempted while empty (outside fbls)
//
//   Configuration:
//     NEIGHBORS_ABOVE_BUF_ERR_EN : when defined, the sticky error flags are
//     built. When undefined, both flags are tied to 0 and have no registers.
// ----------------------------------------------------------------------------
module neighbors_above_buf #(
    parameter int MAX_SLICE_WIDTH = 2560,
    parameter int BITS            = 14,
    localparam int DEPTH          = MAX_SLICE_WIDTH / 8,
    localparam int CNT_W          = $clog2(DEPTH + 1)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    input  logic                        sos,
    neighbors_above_buf_if.slave        bus,
    output logic [CNT_W-1:0]            count,
    output logic                        full,
    output logic                        empty,
    output logic                        overflow_err,
    output logic                        underflow_err
);
    localparam int ENTRY_W = 24 * BITS;
    localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Mid-grey sample (1 << (BITS-1)) replicated across 8 samples x 3 components.
    localparam logic [BITS-1:0]    DEF_SAMPLE = {1'b1, {(BITS-1){1'b0}}};
    localparam logic [ENTRY_W-1:0] DEF_ROW    = {24{DEF_SAMPLE}};

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   cnt;
    logic               rd_valid_q;
    logic [ENTRY_W-1:0] rd_data_q;

    logic full_i;
    logic empty_i;
    logic clear;
    logic wr_accept;
    logic rd_req;
    logic rd_pop;

    assign full_i  = (cnt == CNT_W'(DEPTH));
    assign empty_i = (cnt == '0);

    // flush and sos both discard the same-cycle wr_en/rd_en.
    assign clear     = flush | sos;
    // full/empty come from the registered count, so a same-cycle pop never
    // frees a slot for a write, and a same-cycle write is never bypassed to a read.
    assign wr_accept = ~clear & bus.wr_en & ~full_i;
    assign rd_req    = ~clear & bus.rd_en;
    assign rd_pop    = rd_req & ~bus.fbls & ~empty_i;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Storage has no reset. Outputs only read slots that have been written.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            cnt        <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else if (clear) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            cnt        <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (rd_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({wr_accept, rd_pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
            rd_valid_q <= rd_req;
            if (rd_req) begin
                rd_data_q <= rd_pop ? mem[rd_ptr] : DEF_ROW;
            end
        end
    end

`ifdef NEIGHBORS_ABOVE_BUF_ERR_EN
    logic ovf_q;
    logic unf_q;
    logic wr_reject;
    logic rd_under;

    assign wr_reject = ~clear & bus.wr_en & full_i;
    assign rd_under  = rd_req & ~bus.fbls & empty_i;

    // Flags are sticky. Only flush or reset clear them. sos keeps them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else if (flush) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (wr_reject) ovf_q <= 1'b1;
            if (rd_under)  unf_q <= 1'b1;
        end
    end

    assign overflow_err  = ovf_q;
    assign underflow_err = unf_q;
`else
    assign overflow_err  = 1'b0;
    assign underflow_err = 1'b0;
`endif

    assign count        = cnt;
    assign full         = full_i;
    assign empty        = empty_i;
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_data  = rd_data_q;

endmodule

// File: tb/tb_neighbors_above_buf.sv
// ----------------------------------------------------------------------------
// tb_neighbors_above_buf
//   Self-checking bench for neighbors_above_buf. A queue-based reference model
//   tracks buffer contents, the sticky flags and the registered read port.
//   Directed sequences cover fbls reads, fill/overflow, drain/wrap, concurrent
//   read+write, empty read with a same-cycle write, sos/flush and reset in the
//   middle of operation. A randomized phase follows.
// ----------------------------------------------------------------------------
module tb_neighbors_above_buf;
    localparam int MAX_SLICE_WIDTH = 2560;
    localparam int BITS            = 14;
    localparam int DEPTH           = MAX_SLICE_WIDTH / 8;
    localparam int ENTRY_W         = 24 * BITS;
    localparam int CNT_W           = $clog2(DEPTH + 1);
    localparam int RW_W            = ((ENTRY_W + 31) / 32) * 32;

`ifdef NEIGHBORS_ABOVE_BUF_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic sos   = 1'b0;
    logic [CNT_W-1:0] count;
    logic full, empty, overflow_err, underflow_err;

    always #5 clk = ~clk;

    neighbors_above_buf_if #(.BITS(BITS)) bus ();

    neighbors_above_buf #(
        .MAX_SLICE_WIDTH (MAX_SLICE_WIDTH),
        .BITS            (BITS)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .sos           (sos),
        .bus           (bus),
        .count         (count),
        .full          (full),
        .empty         (empty),
        .overflow_err  (overflow_err),
        .underflow_err (underflow_err)
    );

    // ---------------- scoreboard / model ----------------
    logic [ENTRY_W-1:0] exp_q[$];
    logic [ENTRY_W-1:0] m_data;
    bit                 m_valid;
    bit                 m_ovf;
    bit                 m_unf;
    int                 checks   = 0;
    int                 failures = 0;

    function automatic logic [ENTRY_W-1:0] default_row();
        logic [ENTRY_W-1:0] r;
        r = '0;
        for (int s = 0; s < 24; s++) begin
            r[s*BITS +: BITS] = BITS'(2 ** (BITS - 1));
        end
        return r;
    endfunction

    function automatic logic [ENTRY_W-1:0] rand_entry();
        logic [RW_W-1:0] t;
        for (int i = 0; i < RW_W / 32; i++) begin
            t[i*32 +: 32] = $urandom;
        end
        return t[ENTRY_W-1:0];
    endfunction

    task automatic check(input string tag, input logic [ENTRY_W-1:0] got,
                         input logic [ENTRY_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        check("rd_valid", ENTRY_W'(bus.rd_valid), ENTRY_W'(m_valid));
        check("rd_data", bus.rd_data, m_data);
        check("count", ENTRY_W'(count), ENTRY_W'(exp_q.size()));
        check("full", ENTRY_W'(full), ENTRY_W'(exp_q.size() == DEPTH));
        check("empty", ENTRY_W'(empty), ENTRY_W'(exp_q.size() == 0));
        check("overflow_err", ENTRY_W'(overflow_err), ENTRY_W'(ERR_EN & m_ovf));
        check("underflow_err", ENTRY_W'(underflow_err), ENTRY_W'(ERR_EN & m_unf));
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_valid = 1'b0;
        m_data  = '0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
    endtask

    // One clock edge of the buffer, described at the level of the rules:
    // read decisions use pre-edge occupancy, then the write is appended.
    task automatic model_update(input bit f, input bit s, input bit fb,
                                input bit we, input bit re,
                                input logic [ENTRY_W-1:0] wd);
        int n;
        n = exp_q.size();
        if (f) begin
            exp_q.delete();
            m_valid = 1'b0;
            m_ovf   = 1'b0;
            m_unf   = 1'b0;
        end else if (s) begin
            exp_q.delete();
            m_valid = 1'b0;
        end else begin
            m_valid = re;
            if (re) begin
                if (fb) begin
                    m_data = default_row();
                end else if (n == 0) begin
                    m_data = default_row();
                    m_unf  = 1'b1;
                end else begin
                    m_data = exp_q.pop_front();
                end
            end
            if (we) begin
                if (n == DEPTH) m_ovf = 1'b1;
                else            exp_q.push_back(wd);
            end
        end
    endtask

    // ---------------- driver ----------------
    task automatic step(input bit f, input bit s, input bit fb, input bit we,
                        input bit re, input logic [ENTRY_W-1:0] wd);
        @(negedge clk);
        flush       = f;
        sos         = s;
        bus.fbls    = fb;
        bus.wr_en   = we;
        bus.wr_data = wd;
        bus.rd_en   = re;
        @(posedge clk);
        model_update(f, s, fb, we, re, wd);
        #1;
        check_all();
    endtask

    task automatic write_n(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 1, 0, rand_entry());
    endtask

    task automatic read_n(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 1, rand_entry());
    endtask

    task automatic mid_reset();
        @(negedge clk);
        flush     = 1'b0;
        sos       = 1'b0;
        bus.fbls  = 1'b0;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bus.fbls    = 1'b0;
        bus.wr_en   = 1'b0;
        bus.rd_en   = 1'b0;
        bus.wr_data = '0;
        model_reset();
        #12;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // fbls read returns the default row without popping
        step(0, 0, 1, 0, 1, '0);
        step(0, 0, 0, 0, 0, '0);

        // fill to full, then an extra write is dropped
        write_n(DEPTH);
        step(0, 0, 0, 1, 0, rand_entry());
        // full + simultaneous read: the write is still dropped
        step(0, 0, 0, 1, 1, rand_entry());

        // drain everything, in order, with pointer wrap
        read_n(DEPTH - 1);
        step(0, 0, 0, 0, 0, '0);

        // steady state at count 5 with concurrent read+write
        write_n(5);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 1, rand_entry());
        read_n(5);

        // empty read with same-cycle write: no bypass
        step(0, 0, 0, 1, 1, rand_entry());
        step(0, 0, 0, 0, 0, '0);

        // count 7, sos with rd_en/wr_en ignored, then flush clears flags
        write_n(6);
        step(0, 1, 0, 1, 1, rand_entry());
        step(0, 0, 0, 0, 0, '0);
        write_n(3);
        step(1, 1, 0, 1, 1, rand_entry());
        step(0, 0, 0, 0, 1, '0);

        // randomized phases alternating write-heavy and read-heavy
        for (int ph = 0; ph < 8; ph++) begin
            for (int i = 0; i < 400; i++) begin
                bit we, re, fb, sp, fl;
                we = ($urandom_range(0, 99) < ((ph % 2 == 0) ? 75 : 30));
                re = ($urandom_range(0, 99) < ((ph % 2 == 0) ? 30 : 75));
                fb = ($urandom_range(0, 99) < 10);
                sp = ($urandom_range(0, 999) < 5);
                fl = ($urandom_range(0, 999) < 3);
                step(fl, sp, fb, we, re, rand_entry());
            end
        end

        // reset in the middle of operation discards entries
        write_n(4);
        mid_reset();
        step(0, 0, 0, 0, 1, '0);
        step(0, 0, 0, 0, 0, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
